// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - parity mode codes, transmitter FSM encoding and parity helpers
package uart_pkg;

  localparam logic [2:0] PAR_NONE  = 3'd0;
  localparam logic [2:0] PAR_ODD   = 3'd1;
  localparam logic [2:0] PAR_EVEN  = 3'd2;
  localparam logic [2:0] PAR_MARK  = 3'd3;
  localparam logic [2:0] PAR_SPACE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Reserved codes 5..7 collapse to "no parity bit".
  function automatic logic [2:0] par_mode_norm(input logic [2:0] mode);
    return (mode > PAR_SPACE) ? PAR_NONE : mode;
  endfunction

  function automatic logic par_bit(input logic [2:0] mode, input logic data_xor);
    case (mode)
      PAR_ODD:  return ~data_xor;
      PAR_EVEN: return data_xor;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous first-word-fall-through FIFO with full/empty flags and level
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_valid_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_ready_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    count_q;
  logic             push;
  logic             pop;

  assign full_o    = (count_q == LW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign level_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign push      = wr_valid_i && !full_o;
  assign pop       = rd_ready_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter with runtime baud/parity/stop config
// Define UART_TX_BREAK_EN to add the brk input and line-break generation.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  input  logic [DATA_BITS-1:0]            in_data,
  output logic                            in_ready,
  input  logic [DIV_W-1:0]                cfg_div,
  input  logic [2:0]                      cfg_parity,
  input  logic                            cfg_stop2,
`ifdef UART_TX_BREAK_EN
  input  logic                            brk,
`endif
  output logic                            tx,
  output logic                            busy,
  output logic                            tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  import uart_pkg::*;

  localparam int BCW = $clog2(DATA_BITS+1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS-1);

  tx_state_e            state_q, state_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [DIV_W-1:0]     div_sh_q, div_sh_d;
  logic [2:0]           mode_sh_q, mode_sh_d;
  logic                 stop2_sh_q, stop2_sh_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 avail_q;
  logic                 bit_tick;
  logic                 start_frame;
  logic                 start_ok;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;
`ifdef UART_TX_BREAK_EN
  logic                 brk_gap_q, brk_gap_d;
`endif

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid_i (in_valid),
    .wr_data_i  (in_data),
    .rd_ready_i (start_frame),
    .rd_data_o  (fifo_rdata),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (fifo_level)
  );

  assign in_ready = !fifo_full;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;
  assign bit_tick = (div_cnt_q == div_sh_q);

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    div_sh_d    = div_sh_q;
    mode_sh_d   = mode_sh_q;
    stop2_sh_d  = stop2_sh_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    start_frame = 1'b0;
    start_ok    = 1'b1;
`ifdef UART_TX_BREAK_EN
    brk_gap_d   = brk_gap_q;
    start_ok    = !brk && !brk_gap_q;
`endif

    if (state_q != ST_IDLE) div_cnt_d = bit_tick ? '0 : div_cnt_q + DIV_W'(1);

    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
`ifdef UART_TX_BREAK_EN
        // After a break the line must rest high for a full bit before the next start.
        if (brk) begin
          tx_d      = 1'b0;
          brk_gap_d = 1'b1;
          div_cnt_d = '0;
        end else if (brk_gap_q) begin
          if (div_cnt_q >= cfg_div) begin
            brk_gap_d = 1'b0;
            div_cnt_d = '0;
          end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
          end
        end
`endif
        // avail_q delays a fresh push by one cycle before it can start a frame.
        if (start_ok && avail_q && !fifo_empty) start_frame = 1'b1;
      end
      ST_START: begin
        if (bit_tick) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          par_d   = par_q ^ shift_q[0];
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (mode_sh_q != PAR_NONE) begin
              state_d = ST_PARITY;
              tx_d    = par_bit(mode_sh_q, par_d);
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
            tx_d      = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          state_d   = ST_STOP;
          bit_cnt_d = '0;
          tx_d      = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (stop2_sh_q && bit_cnt_q == '0) begin
            bit_cnt_d = BCW'(1);
          end else begin
            done_d    = 1'b1;
            bit_cnt_d = '0;
            if (start_ok && !fifo_empty) begin
              start_frame = 1'b1;
            end else begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
              busy_d  = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Frame start: pop the word and freeze the configuration for the whole frame.
    if (start_frame) begin
      state_d    = ST_START;
      tx_d       = 1'b0;
      busy_d     = 1'b1;
      div_cnt_d  = '0;
      bit_cnt_d  = '0;
      shift_d    = fifo_rdata;
      par_d      = 1'b0;
      div_sh_d   = cfg_div;
      mode_sh_d  = par_mode_norm(cfg_parity);
      stop2_sh_d = cfg_stop2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      div_sh_q   <= '0;
      mode_sh_q  <= PAR_NONE;
      stop2_sh_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      avail_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      div_sh_q   <= div_sh_d;
      mode_sh_q  <= mode_sh_d;
      stop2_sh_q <= stop2_sh_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      avail_q    <= !fifo_empty;
    end
  end

`ifdef UART_TX_BREAK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) brk_gap_q <= 1'b0;
    else        brk_gap_q <= brk_gap_d;
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo: directed words, line monitor checks frames
module tb_uart_tx_fifo;

  localparam int DB = 8;
  localparam int FD = 16;
  localparam int DW = 16;
  localparam int LW = $clog2(FD+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DB-1:0] in_data = '0;
  logic          in_ready;
  logic [DW-1:0] cfg_div = 16'd3;
  logic [2:0]    cfg_parity = 3'd0;
  logic          cfg_stop2 = 1'b0;
`ifdef UART_TX_BREAK_EN
  logic          brk = 1'b0;
`endif
  logic          tx;
  logic          busy;
  logic          tx_done;
  logic [LW-1:0] fifo_level;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_BITS(DB), .FIFO_DEPTH(FD), .DIV_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .cfg_div    (cfg_div),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
`ifdef UART_TX_BREAK_EN
    .brk        (brk),
`endif
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done),
    .fifo_level (fifo_level)
  );

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         has_par;
    bit         par_bit;
    int         nstop;
    bit         nogap;
    int         lvl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   frames_done = 0;
  int   done_cnt = 0;
  int   gap_cnt = 0;
  bit   mon_en = 1'b1;
  bit   in_frame = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input int div, input int par,
                              input int nstop, input bit nogap, input int lvl);
    exp_t e;
    e.data = d; e.div = div; e.has_par = (par >= 0); e.par_bit = (par == 1);
    e.nstop = nstop; e.nogap = nogap; e.lvl = lvl;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input exp_t e, input bit enq);
    int n = 0;
    in_valid = 1'b1;
    in_data  = e.data;
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("push_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (enq) exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || in_frame || busy) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, (exp_q.size() == 0 && !in_frame && !busy) ? 1 : 0, 1);
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) if (tx_done === 1'b1) done_cnt++;

  initial begin : monitor
    exp_t e;
    logic bits [16];
    int   nb;
    int   badb;
    int   n;
    bit   skip;
    skip = 1'b0;
    forever begin
      if (!skip) @(negedge clk);
      skip = 1'b0;
      if (!mon_en) begin
        gap_cnt = 0;
      end else if (tx === 1'b1) begin
        gap_cnt++;
      end else if (exp_q.size() == 0) begin
        check("unexpected_frame", 1, 0);
        n = 0;
        while (tx !== 1'b1 && n < 5000) begin
          @(negedge clk);
          n++;
        end
      end else begin
        in_frame = 1'b1;
        e = exp_q.pop_front();
        if (e.nogap) check($sformatf("gap_before_%02h", e.data), gap_cnt, 0);
        if (e.lvl >= 0) check($sformatf("level_at_start_%02h", e.data), int'(fifo_level), e.lvl);
        nb = 0;
        bits[nb] = 1'b0; nb++;
        for (int i = 0; i < 8; i++) begin bits[nb] = e.data[i]; nb++; end
        if (e.has_par) begin bits[nb] = e.par_bit; nb++; end
        for (int s = 0; s < e.nstop; s++) begin bits[nb] = 1'b1; nb++; end
        badb = -1;
        for (int b = 0; b < nb; b++) begin
          for (int c = 0; c <= e.div; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (tx !== bits[b] || busy !== 1'b1 ||
                (tx_done !== 1'b0 && !(b == 0 && c == 0))) begin
              if (badb < 0) badb = b;
            end
          end
        end
        @(negedge clk);
        check($sformatf("frame_%02h_first_bad_bit", e.data), badb, -1);
        check($sformatf("tx_done_after_%02h", e.data), int'(tx_done), 1);
        frames_done++;
        gap_cnt  = 0;
        in_frame = 1'b0;
        skip     = 1'b1;
      end
    end
  end

  initial begin : stimulus
    int par_exp [8] = '{-1, 0, 1, 1, 0, -1, -1, -1};
    logic [2:0] lat;
    int fd0;
    int ones;

    repeat (3) @(negedge clk);
    check("reset_tx", int'(tx), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_tx_done", int'(tx_done), 0);
    check("reset_level", int'(fifo_level), 0);
    check("reset_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single 0xA5, div 3, no parity, one stop
    cfg_div = 16'd3; cfg_parity = 3'd0; cfg_stop2 = 1'b0;
    push(mk(8'hA5, 3, -1, 1, 1'b0, 0), 1'b1);
    lat[2] = tx; @(negedge clk);
    lat[1] = tx; @(negedge clk);
    lat[0] = tx;
    check("start_latency_k2", int'(lat), 3'b110);
    wait_idle("drain_a5", 200);
    check("tx_done_count_a5", done_cnt, 1);

    // Back-to-back with two stop bits, queued behind 0x55
    cfg_stop2 = 1'b1;
    push(mk(8'h55, 3, -1, 2, 1'b0, -1), 1'b1);
    push(mk(8'h00, 3, -1, 2, 1'b1, 2), 1'b1);
    push(mk(8'hFF, 3, -1, 2, 1'b1, 1), 1'b1);
    push(mk(8'h3C, 3, -1, 2, 1'b1, 0), 1'b1);
    check("level_peak", int'(fifo_level), 3);
    wait_idle("drain_b2b", 400);

    // Parity sweep on 0x07
    cfg_stop2 = 1'b0; cfg_div = 16'd1;
    for (int m = 1; m <= 7; m++) begin
      cfg_parity = 3'(m);
      push(mk(8'h07, 1, par_exp[m], 1, 1'b0, -1), 1'b1);
      wait_idle($sformatf("drain_par%0d", m), 100);
    end

    // Fill the FIFO behind a slow frame
    cfg_parity = 3'd0; cfg_div = 16'd99;
    fd0 = frames_done;
    push(mk(8'h80, 99, -1, 1, 1'b0, -1), 1'b1);
    for (int i = 1; i <= 16; i++) push(mk(8'(i * 13), 1, -1, 1, 1'b1, -1), 1'b1);
    cfg_div = 16'd1;
    check("fill_level", int'(fifo_level), 16);
    check("fill_in_ready", int'(in_ready), 0);
    push(mk(8'hEE, 1, -1, 1, 1'b1, -1), 1'b1);
    check("held_word_after_first_pop", frames_done - fd0, 1);
    wait_idle("drain_fill", 3000);

    // Divisor change while a frame is in flight
    cfg_div = 16'd3;
    push(mk(8'h5A, 3, -1, 1, 1'b0, -1), 1'b1);
    push(mk(8'hC3, 7, -1, 1, 1'b1, -1), 1'b1);
    repeat (10) @(negedge clk);
    cfg_div = 16'd7;
    wait_idle("drain_cfgchg", 300);
    check("tx_done_total", done_cnt, 32);
    check("frames_total", frames_done, 32);

    // Reset in the middle of a data bit
    mon_en = 1'b0;
    cfg_div = 16'd3;
    push(mk(8'hF0, 3, -1, 1, 1'b0, -1), 1'b0);
    push(mk(8'h11, 3, -1, 1, 1'b0, -1), 1'b0);
    push(mk(8'h22, 3, -1, 1, 1'b0, -1), 1'b0);
    repeat (6) @(negedge clk);
    check("busy_before_reset", int'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_level", int'(fifo_level), 0);
    check("rst_tx_done", int'(tx_done), 0);
    check("rst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    ones = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx === 1'b1 && busy === 1'b0) ones++;
    end
    check("idle_after_flush", ones, 20);

`ifdef UART_TX_BREAK_EN
    brk = 1'b1;
    ones = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx === 1'b0) ones++;
    end
    check("break_low_cycles", ones, 20);
    brk = 1'b0;
    repeat (2) @(negedge clk);
    check("break_release_high", int'(tx), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered, parametrised UART transmitter: accepts words over a valid/ready stream into an internal FIFO and serialises them back-to-back on `tx`, with a runtime-programmable baud divisor, parity mode and stop-bit count. It sits between the bus-side register block and the pad, replacing the single-word request/acknowledge transmitter where sustained throughput or runtime reconfiguration is needed.

## Interface
- `DATA_BITS`, 8: frame data width, legal range 5..9.
- `FIFO_DEPTH`, 16: buffered words; must be a power of two and at least 2.
- `DIV_W`, 16: width of the baud divisor.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  word offered.
- `in_data`  in  DATA_BITS  word, LSB sent first.
- `in_ready`  out  1  FIFO not full.
- `cfg_div`  in  DIV_W  bit period minus one, in clk cycles; must be at least 1.
- `cfg_parity`  in  3  parity mode: 0 none, 1 odd, 2 even, 3 mark, 4 space; 5..7 are treated as none.
- `cfg_stop2`  in  1  when 1, send two stop bits; when 0, send one.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  a frame is in progress.
- `tx_done`  out  1  one-cycle pulse when a frame's last stop bit completes.
- `fifo_level`  out  $clog2(FIFO_DEPTH+1)  number of words held.
- `brk`  in  1  break request; present only with `UART_TX_BREAK_EN`.

## Operation
- A word is accepted on any edge where `in_valid && in_ready`. `in_ready` is `!full`. Words are never dropped.
- FSM states:
  - IDLE to START when the FIFO is not empty. The word is popped, `tx` goes to 0, `cfg_*` is latched into shadow registers, and parity is cleared.
  - START to DATA after one bit period.
  - DATA shifts out LSB-first and accumulates the XOR of the data bits. After `DATA_BITS` bits it goes to PARITY if the latched mode is non-zero, otherwise to STOP.
  - PARITY outputs, per mode: odd gives `~xor`, even gives `xor`, mark gives 1, space gives 0. It lasts one bit period, then goes to STOP.
  - STOP drives `tx` = 1 for 1 or 2 bit periods.
- On STOP expiry, `tx_done` pulses. If the FIFO is not empty, the FSM goes directly to START (same edge, zero idle gap). Otherwise it goes to IDLE.
- Config changes mid-frame do not affect the current frame; they take effect at the next START.
- Simultaneous push and pop: `fifo_level` is unchanged. A push when full is impossible because `in_ready` is 0. A push into an empty FIFO is not visible to the FSM until the next cycle.
- Bit counter width: $clog2(DATA_BITS+1). Delay counter width: `DIV_W`. Both wrap to 0 at each bit boundary.
- Reset mid-frame aborts the frame, flushes the FIFO, and returns `tx` high on the next edge.

## Timing
- Reset values: `tx`=1, `busy`=0, `tx_done`=0, `fifo_level`=0, `in_ready`=1 (combinational from the empty FIFO). All outputs except `in_ready` are registered.
- Latency: word accepted at edge k; `tx` falls at edge k+2.
- Each bit lasts exactly `cfg_div`+1 cycles.
- Frame length is (1+`DATA_BITS`+p+s)*(`cfg_div`+1) cycles, where p is 0 or 1 for parity and s is 1 or 2 for stop bits.
- `busy` is 1 from the START edge through the final STOP edge.
- `tx_done` is high for exactly the cycle after that final edge.

## Configuration
- `UART_TX_BREAK_EN` defined:
  - `brk` port exists.
  - When `brk`=1 and the FSM is in IDLE, `tx` is held 0 and no pop occurs.
  - A `brk` asserted mid-frame is honoured only after the current frame completes.
  - On `brk` release, at least one bit period of `tx`=1 precedes the next START.
- Not defined: no `brk` port, and break logic is absent.

## Structure
- Package `uart_pkg` holds:
  - parity mode constants `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`, `PAR_MARK`, `PAR_SPACE`;
  - the FSM state encoding.
- Sub-module `sync_fifo`, parametrised by width and depth, with:
  - full/empty flags and level output;
  - first-word-fall-through read;
  - reusable by the future receiver.

## Test plan
- `cfg_div`=3, parity none, 1 stop; push 0xA5 → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, 40 cycles total; `tx_done` pulses once.
- Push 0x00, 0xFF, 0x3C back-to-back with 2 stop bits → three frames with no idle cycle between them; `fifo_level` reaches 3 then decrements on each START.
- Parity sweep on 0x07 → odd gives 0, even gives 1, mark gives 1, space gives 0; modes 5..7 give a frame without a parity bit.
- Fill 16 words while `tx` is stalled by a long `cfg_div` → `in_ready`=0, the 17th word is held, and it is accepted after the first pop.
- Change `cfg_div` 3→7 mid-frame → current frame keeps 4-cycle bits; next frame uses 8-cycle bits.
- Assert `rst_n`=0 mid-data-bit → next cycle `tx`=1, `fifo_level`=0, `busy`=0. With `UART_TX_BREAK_EN`, `brk` held 20 cycles in IDLE gives `tx`=0 for 20 cycles.
